// File: rtl/synth_pkg.sv
// synth_pkg: constants shared by the small synthesis-module set.
//   DEFAULT_WIDTH : default operand width for the sequential multiplier
//   ST_IDLE/ST_RUN/ST_DONE : legacy-compatible FSM state encodings
package synth_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rca_n.sv
// rca_n: WIDTH-bit ripple-carry adder built from a chain of bit1_FA cells.
// bit1_FA ports:
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
// rca_n ports:
//   A, B : WIDTH-bit addends
//   Cin  : carry into bit 0
//   Sum  : WIDTH-bit sum
//   Cout : carry out of the MSB
module bit1_FA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Classic full adder: propagate term reused for the carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

module rca_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  // carry[i] feeds bit i; carry[WIDTH] is the adder carry-out.
  logic [WIDTH:0] carry;

  assign carry[0] = Cin;
  assign Cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit1_FA u_fa (
      .a   (A[i]),
      .b   (B[i]),
      .cin (carry[i]),
      .sum (Sum[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/seq_mul_rca.sv
// seq_mul_rca: sequential unsigned shift-and-add multiplier wrapped around a
// single rca_n adder. One partial product is added per clock; the result is
// WIDTH x WIDTH -> 2*WIDTH bits with valid/ready handshakes on both sides.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   In_valid  : operand pair A/B valid
//   In_ready  : block can accept operands (IDLE only)
//   A, B      : multiplicand / multiplier (sampled only on the accept edge)
//   Out_valid : Product valid (DONE state)
//   Out_ready : downstream accepts Product
//   Product   : A*B, unsigned, held stable while Out_valid && !Out_ready
//   Busy      : high in RUN state
// Optional feature macro: SEQ_MUL_ZERO_SKIP_EN -- a zero operand on the accept
// edge jumps straight to DONE with a zero result, skipping RUN entirely.
module seq_mul_rca
  import synth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // The multiplier LSB selects whether this step adds M or nothing.
  assign addend = q_q[0] ? m_q : '0;

  rca_n #(.WIDTH(WIDTH)) u_add (
    .A   (acc_q),
    .B   (addend),
    .Cin (1'b0),
    .Sum (sum),
    .Cout(cout)
  );

  // Next-state logic. In RUN the whole {C,S,Q} word shifts right by one so
  // the adder carry lands in the Acc MSB and is never lost.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (In_valid) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = ST_RUN;
`ifdef SEQ_MUL_ZERO_SKIP_EN
          if (A == '0 || B == '0) begin
            q_d     = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        acc_d = {cout, sum[WIDTH-1:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are pure state decodes, so In_ready never depends on
  // In_valid combinationally.
  assign In_ready  = (state_q == ST_IDLE);
  assign Busy      = (state_q == ST_RUN);
  assign Out_valid = (state_q == ST_DONE);
  assign Product   = Out_valid ? {acc_q, q_q} : '0;

endmodule

// File: doc/seq_mul_rca.md
Name: seq_mul_rca

Overview:
- Sequential unsigned shift-and-add multiplier that sits directly around an N-bit ripple-carry adder stage.
- It feeds the adder one partial product per clock and consumes its sum and carry-out.
- It turns the combinational adder into a multi-cycle WIDTH x WIDTH multiplier with valid/ready handshakes on both sides.
- Targeted at the small synthesis-module set as the first block with a registered datapath.

Parameters:
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- In_valid  input  1  operand pair A/B is valid
- In_ready  output  1  block can accept operands
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- Out_valid  output  1  Product is valid
- Out_ready  input  1  downstream accepts Product
- Product  output  2*WIDTH  A*B, unsigned
- Busy  output  1  high in RUN state

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. Assertion immediately forces the reset state; deassertion is sampled on clk.
- Reset values: state=IDLE, In_ready=1, Out_valid=0, Busy=0, Product=0, all internal registers 0.
- Internal registers:
  - M (WIDTH): latched multiplicand.
  - Acc (WIDTH): upper partial product.
  - Q (WIDTH): multiplier / lower product.
  - Cnt: $clog2(WIDTH+1) bits.
- States:
  - IDLE: In_ready=1. On In_valid&&In_ready, latch M=A, Q=B, Acc=0, Cnt=WIDTH, and go to RUN.
  - RUN: In_ready=0, Busy=1. Each clock the adder computes {C,S}=Acc+(Q[0]?M:0) with carry-in 0. Then {Acc,Q} <= {C,S,Q[WIDTH-1:1]} and Cnt decrements. When Cnt reaches 1 at a clock edge, go to DONE.
  - DONE: Out_valid=1, Product={Acc,Q}, held stable while Out_ready=0. On Out_valid&&Out_ready, go to IDLE and drop Out_valid on the next edge.
- Latency:
  - Accept at edge t; Out_valid high after edge t+WIDTH.
  - Throughput is one product per WIDTH+2 cycles minimum: accept, WIDTH iterations, output handshake. No overlap is allowed.
- Handshakes:
  - In_ready depends only on state (no combinational path from In_valid).
  - Out_valid must not drop without Out_ready.
  - A and B are ignored outside the accept cycle.
- Width rules:
  - Adder carry-out is never lost; it shifts into Acc MSB.
  - Maximum product (2^WIDTH-1)^2 fits in 2*WIDTH bits, so no overflow is possible.
- Boundary cases:
  - A=0 or B=0: product 0 with normal latency (unless ZERO_SKIP_EN).
  - In_valid asserted during RUN or DONE: ignored and stalled (In_ready=0).
  - Out_ready high in IDLE or RUN: no effect.
  - rst mid-RUN or mid-DONE: result discarded, IDLE immediately, Out_valid=0.

Optional Feature:
- Macro: SEQ_MUL_ZERO_SKIP_EN
- Defined: if A==0 or B==0 on the accept edge, go straight to DONE with Acc=0, Q=0. Out_valid is then high after edge t+1, and Busy never asserts for that transaction.
- Undefined: all operands take the full WIDTH iterations; there is no zero-detect logic.

Decomposition:
- Shared package synth_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module rca_n (WIDTH-parameterized ripple-carry adder built from bit1_FA):
  - Inputs A, B, Cin; outputs Sum, Cout.
  - Instantiated once for the Acc+M add.
- FSM and shift registers stay in seq_mul_rca.

Test Plan:
- Reset then A=15, B=15, In_valid pulse, Out_ready=1: In_ready falls next cycle; Out_valid after exactly 4 edges; Product=8'hE1 (225).
- A=13, B=11: Product=8'h8F (143). Then A=1, B=1 immediately after handshake: Product=8'h01. Each accept occurs only when In_ready=1.
- A=0, B=9: Product=0 after 4 edges without macro, after 1 edge with SEQ_MUL_ZERO_SKIP_EN. Busy must stay 0 with the macro.
- A=6, B=7 with Out_ready=0 for 5 cycles: Out_valid stays 1, Product holds 8'h2A, and In_valid pulses in those cycles are not accepted. Raise Out_ready: one handshake, then back to IDLE.
- Assert rst asynchronously mid-RUN (2 edges after accept of A=9, B=5): outputs go to reset values before the next clk edge. The next transaction A=3, B=4 yields 8'h0C.
- Exhaustive: all 256 A/B pairs back-to-back with random Out_ready stalls; compare against A*B, with one result per accepted pair and no duplicates or drops.
